// File: rtl/leiwand_rv32_wb_ram.sv
// leiwand_rv32_wb_ram: single-port Wishbone (pipelined) slave RAM with byte-lane
// write enables, programmable wait states and an error response for addresses
// beyond MEM_SIZE. One transaction is in flight at a time.
// Optional build macro INIT_RAM_TOZERO_EN: after reset, sweep the whole array
// writing zero (one word per cycle) before accepting requests.
//
// state  | meaning
// INIT   | post-reset; stalls (and zero-sweeps when INIT_RAM_TOZERO_EN is set)
// IDLE   | ready; accepts a request when cyc & stb
// WAIT   | counting down programmed wait states
// RESP   | performs the access, registers ack/err and returns to IDLE

`ifndef HIGH_BIT_TO_FIT
`define HIGH_BIT_TO_FIT(v) (((v) < 2) ? 0 : ($clog2((v) + 1) - 1))
`endif

module leiwand_rv32_wb_ram #(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_SIZE      = 1024,
   parameter int ADDR_HIGH_BIT = `HIGH_BIT_TO_FIT(MEM_SIZE - 1),
   parameter int WAIT_STATES   = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [ADDR_HIGH_BIT:0]    i_addr,
   input  logic [DATA_WIDTH-1:0]     i_dat,
   input  logic [DATA_WIDTH/8-1:0]   i_sel,
   input  logic                      i_we,
   input  logic                      i_stb,
   input  logic                      i_cyc,
   output logic [DATA_WIDTH-1:0]     o_dat,
   output logic                      o_ack,
   output logic                      o_err,
   output logic                      o_stall
);

   localparam int SEL_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state;
   logic [3:0]              wait_cnt;
   logic [ADDR_HIGH_BIT:0]  addr_q;
   logic [DATA_WIDTH-1:0]   dat_q;
   logic [SEL_W-1:0]        sel_q;
   logic                    we_q;
   logic                    in_range;
   logic                    do_write;

   logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

`ifdef INIT_RAM_TOZERO_EN
   logic [ADDR_HIGH_BIT:0]  init_idx;
   logic                    init_done;
`endif

   // The latched address may exceed MEM_SIZE when MEM_SIZE is not a power of two.
   assign in_range = (int'(addr_q) < MEM_SIZE);

   // A write lands only on the RESP edge of a live, in-range, non-reset cycle.
   assign do_write = (state == S_RESP) && i_cyc && !i_rst && in_range && we_q;

   // Memory array: byte-lane writes, plus the optional zero sweep; never reset.
   always_ff @(posedge i_clk) begin
`ifdef INIT_RAM_TOZERO_EN
      if (!i_rst && state == S_INIT && !init_done) begin
         mem[init_idx] <= '0;
      end
`endif
      if (do_write) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (sel_q[b]) begin
               mem[addr_q][8*b +: 8] <= dat_q[8*b +: 8];
            end
         end
      end
   end

   // Bus-side FSM with registered ack/err/stall/read data.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_INIT;
         o_ack    <= 1'b0;
         o_err    <= 1'b0;
         o_dat    <= '0;
         o_stall  <= 1'b1;
         wait_cnt <= '0;
`ifdef INIT_RAM_TOZERO_EN
         init_idx  <= '0;
         init_done <= 1'b0;
`endif
      end else begin
         o_ack <= 1'b0;
         o_err <= 1'b0;
         o_dat <= '0;
         unique case (state)
            S_INIT: begin
`ifdef INIT_RAM_TOZERO_EN
               if (init_done) begin
                  state   <= S_IDLE;
                  o_stall <= 1'b0;
               end else if (init_idx == (ADDR_HIGH_BIT+1)'(MEM_SIZE - 1)) begin
                  init_done <= 1'b1;
               end else begin
                  init_idx <= init_idx + 1'b1;
               end
`else
               state   <= S_IDLE;
               o_stall <= 1'b0;
`endif
            end
            S_IDLE: begin
               if (i_cyc && i_stb && !o_stall) begin
                  addr_q  <= i_addr;
                  dat_q   <= i_dat;
                  sel_q   <= i_sel;
                  we_q    <= i_we;
                  o_stall <= 1'b1;
                  if (WAIT_STATES > 0) begin
                     state    <= S_WAIT;
                     wait_cnt <= 4'(WAIT_STATES - 1);
                  end else begin
                     state <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               if (!i_cyc) begin
                  state   <= S_IDLE;
                  o_stall <= 1'b0;
               end else if (wait_cnt == 4'd0) begin
                  state <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               o_stall <= 1'b0;
               if (i_cyc) begin
                  if (!in_range) begin
                     o_err <= 1'b1;
                  end else begin
                     o_ack <= 1'b1;
                     if (!we_q) begin
                        o_dat <= mem[addr_q];
                     end
                  end
               end
            end
            default: begin
               state   <= S_INIT;
               o_stall <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leiwand_rv32_wb_ram.sv
// tb_leiwand_rv32_wb_ram: directed and randomized bus traffic against a
// transaction-level model (word array plus response-time bookkeeping) that
// predicts ack/err/stall/read data for every cycle.
module tb_leiwand_rv32_wb_ram;

`ifdef INIT_RAM_TOZERO_EN
   localparam int MS   = 16;
   localparam bit FEAT = 1'b1;
   localparam int EXP_INIT = 17;
`else
   localparam int MS   = 1000;
   localparam bit FEAT = 1'b0;
   localparam int EXP_INIT = 1;
`endif
   localparam int WS = 3;
   localparam int AW = $clog2(MS);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [31:0]   dat = '0;
   logic [3:0]    sel = '0;
   logic          we = 1'b0;
   logic          stb = 1'b0;
   logic          cyc = 1'b0;
   logic [31:0]   rdat;
   logic          ack, err, stall;

   leiwand_rv32_wb_ram #(
      .DATA_WIDTH(32), .MEM_SIZE(MS), .ADDR_HIGH_BIT(AW-1), .WAIT_STATES(WS)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_dat(dat), .i_sel(sel),
      .i_we(we), .i_stb(stb), .i_cyc(cyc),
      .o_dat(rdat), .o_ack(ack), .o_err(err), .o_stall(stall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // transaction-level model
   logic [31:0]   m_mem   [2**AW];
   bit            m_known [2**AW];
   int            n = 0;
   int            idle_at = 1;
   bit            busy = 1'b0;
   int            resp_at = 0;
   logic [AW-1:0] l_addr;
   logic [31:0]   l_dat;
   logic [3:0]    l_sel;
   logic          l_we;
   bit            e_ack, e_err, e_stall, e_dat_known;
   logic [31:0]   e_dat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, n);
      end
   endtask

   task automatic model_edge();
      n++;
      e_ack = 1'b0; e_err = 1'b0; e_dat = '0; e_dat_known = 1'b1;
      if (rst) begin
         busy = 1'b0;
         e_stall = 1'b1;
         idle_at = n + (FEAT ? MS + 1 : 1);
      end else if (n < idle_at) begin
         e_stall = 1'b1;
      end else if (n == idle_at) begin
         e_stall = 1'b0;
         if (FEAT) begin
            for (int i = 0; i < MS; i++) begin
               m_mem[i] = '0;
               m_known[i] = 1'b1;
            end
         end
      end else if (busy) begin
         if (!cyc) begin
            busy = 1'b0;
            e_stall = 1'b0;
         end else if (n == resp_at) begin
            busy = 1'b0;
            e_stall = 1'b0;
            if (int'(l_addr) >= MS) begin
               e_err = 1'b1;
            end else begin
               e_ack = 1'b1;
               if (l_we) begin
                  for (int b = 0; b < 4; b++)
                     if (l_sel[b]) m_mem[l_addr][8*b +: 8] = l_dat[8*b +: 8];
                  if (l_sel == 4'hF) m_known[l_addr] = 1'b1;
               end else begin
                  e_dat = m_mem[l_addr];
                  e_dat_known = m_known[l_addr];
               end
            end
         end else begin
            e_stall = 1'b1;
         end
      end else if (cyc && stb) begin
         busy = 1'b1;
         resp_at = n + 1 + WS;
         l_addr = addr; l_dat = dat; l_sel = sel; l_we = we;
         e_stall = 1'b1;
      end else begin
         e_stall = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("stall", 32'(stall), 32'(e_stall));
      chk("ack",   32'(ack),   32'(e_ack));
      chk("err",   32'(err),   32'(e_err));
      if (e_dat_known) chk("dat", rdat, e_dat);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic wait_idle();
      int g = 0;
      while (stall !== 1'b0 && g < 200) begin
         step();
         g++;
      end
      if (g >= 200) begin
         checks++; fails++;
         $display("FAIL idle_timeout: stall still 0x%0h, required 0x0", stall);
      end
   endtask

   // One bus transaction; abort_at>0 drops cyc before that edge after acceptance.
   task automatic txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, input int abort_at,
                      output logic [31:0] rd, output bit got_ack, output bit got_err,
                      output int lat);
      int lim;
      wait_idle();
      cyc = 1'b1; stb = 1'b1; addr = a; dat = d; sel = s; we = w;
      step();
      stb = 1'b0; addr = AW'($urandom); dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      got_ack = 1'b0; got_err = 1'b0; lat = 0; rd = '0;
      lim = (abort_at > 0) ? WS + 3 : 40;
      for (int i = 1; i <= lim; i++) begin
         if (i == abort_at) cyc = 1'b0;
         step();
         if (ack === 1'b1 || err === 1'b1) begin
            got_ack = ack; got_err = err; rd = rdat; lat = i;
            break;
         end
      end
      if (abort_at == 0 && !got_ack && !got_err) begin
         checks++; fails++;
         $display("FAIL resp_timeout: no ack/err after %0d cycles, required one", lim);
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      bit          ga, ge;
      int          lat, cnt;
      int          ack_n[$];

      for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;

      step(); step(); step();
      chk("reset_stall", 32'(stall), 32'd1);
      chk("reset_ack",   32'(ack),   32'd0);
      chk("reset_dat",   rdat,       32'd0);
      rst = 1'b0;
      cnt = 1;
      while (stall === 1'b1 && cnt < 200) begin
         step();
         if (stall === 1'b1) cnt++;
      end
      chk("init_stall_len", cnt, EXP_INIT);

`ifdef INIT_RAM_TOZERO_EN
      txn(AW'(15), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("swept_read15", rd, 32'h0000_0000);
      for (int i = 0; i < 7; i++) step();
      rst = 1'b1; step(); rst = 1'b0;
      cnt = 1;
      while (stall === 1'b1 && cnt < 200) begin
         step();
         if (stall === 1'b1) cnt++;
      end
      chk("restart_stall_len", cnt, 17);
`endif

      txn(AW'(5), 32'hDEAD_BEEF, 4'hF, 1'b1, 0, rd, ga, ge, lat);
      chk("wr5_ack", 32'(ga), 32'd1);
      chk("wr5_latency", lat, 4);
      txn(AW'(5), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("rd5_data", rd, 32'hDEAD_BEEF);
      chk("rd5_latency", lat, 4);

      txn(AW'(5), 32'h0000_0011, 4'h1, 1'b1, 0, rd, ga, ge, lat);
      txn(AW'(5), '0, 4'hF, 1'b0, 0, rd, ga, ge, lat);
      chk("lane0_data", rd, 32'hDEAD_BE11);
      txn(AW'(5), 32'h1234_5678, 4'h0, 1'b1, 0, rd, ga, ge, lat);
      chk("sel0_ack", 32'(ga), 32'd1);
      txn(AW'(5), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("sel0_data", rd, 32'hDEAD_BE11);

`ifndef INIT_RAM_TOZERO_EN
      txn(AW'(1000), 32'hFFFF_FFFF, 4'hF, 1'b0, 0, rd, ga, ge, lat);
      chk("oor_err", 32'(ge), 32'd1);
      chk("oor_ack", 32'(ga), 32'd0);
      chk("oor_dat", rd, 32'd0);
      txn(AW'(999), 32'h1234_5678, 4'hF, 1'b1, 0, rd, ga, ge, lat);
      chk("top_wr_ack", 32'(ga), 32'd1);
      txn(AW'(999), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("top_rd_data", rd, 32'h1234_5678);
`endif

      txn(AW'(7), 32'hAAAA_AAAA, 4'hF, 1'b1, 0, rd, ga, ge, lat);
      txn(AW'(7), 32'h5555_5555, 4'hF, 1'b1, 1, rd, ga, ge, lat);
      chk("abort_wait_resp", 32'(ga | ge), 32'd0);
      txn(AW'(7), 32'h5555_5555, 4'hF, 1'b1, WS + 1, rd, ga, ge, lat);
      chk("abort_resp_resp", 32'(ga | ge), 32'd0);
      txn(AW'(7), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("abort_data", rd, 32'hAAAA_AAAA);

      // reset while a write to addr 7 is waiting
      wait_idle();
      cyc = 1'b1; stb = 1'b1; addr = AW'(7); dat = 32'h0BAD_0BAD; sel = 4'hF; we = 1'b1;
      step();
      stb = 1'b0;
      step();
      rst = 1'b1; step(); rst = 1'b0; cyc = 1'b0;
      chk("rst_mid_ack", 32'(ack), 32'd0);
      txn(AW'(7), '0, 4'h0, 1'b0, 0, rd, ga, ge, lat);
      chk("rst_mid_data", rd, FEAT ? 32'h0 : 32'hAAAA_AAAA);

      // back-to-back reads with strobe held
      wait_idle();
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AW'(5);
      for (int i = 0; i < 22; i++) begin
         step();
         if (ack === 1'b1) ack_n.push_back(n);
         if (stall === 1'b0) addr = (addr == AW'(5)) ? AW'(MS - 1) : AW'(5);
      end
      cyc = 1'b0; stb = 1'b0;
      chk("tput_acks", ack_n.size(), 4);
      for (int i = 1; i < ack_n.size(); i++)
         chk("tput_spacing", ack_n[i] - ack_n[i-1], 5);

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 4000; i++) begin
         cyc  = ($urandom_range(0, 15) != 0);
         stb  = 1'($urandom);
         we   = 1'($urandom);
         addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         dat  = $urandom;
         sel  = 4'($urandom);
         rst  = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
